// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings, FSM states and the
// alignment rule applied when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // A reserved size counts as an error alongside real misalignment.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bus of the load/store unit. The pipeline is the master and the
// LSU is the slave.
interface load_store_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: extracts and extends a load lane from a memory word, and merges a
// store lane into an old word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    unique case (off_i)
      2'd0: byte_lane = word_i[31:24];
      2'd1: byte_lane = word_i[23:16];
      2'd2: byte_lane = word_i[15:8];
      2'd3: byte_lane = word_i[7:0];
    endcase
    half_lane = off_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = unsigned_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merge_o = word_i;
        unique case (off_i)
          2'd0: merge_o[31:24] = wdata_i[7:0];
          2'd1: merge_o[23:16] = wdata_i[7:0];
          2'd2: merge_o[15:8]  = wdata_i[7:0];
          2'd3: merge_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_o  = unsigned_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merge_o = word_i;
        if (off_i[1]) merge_o[15:0] = wdata_i[15:0];
        else          merge_o[31:16] = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: latches one request, sequences word reads/writes to the data
// memory (read-modify-write for sub-word stores) and returns a single-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_W = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic               stall,
  output logic [DEPTH_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [DATA_W-1:0]  mem_rdata
);

  lsu_state_e         state_q, state_d;
  logic               load_q, uns_q, err_q;
  logic [1:0]         size_q, off_q;
  logic [DEPTH_W-1:0] idx_q;
  logic [DATA_W-1:0]  wdata_q, word_q;
  logic [DATA_W-1:0]  load_data, merge_data;
  logic               accept, req_bad;
  logic               unused_addr;

  // Address bits above the memory depth wrap silently.
  assign unused_addr = ^bus.req_addr[DATA_W-1:DEPTH_W+2];

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign req_bad = lsu_misaligned(bus.req_size, bus.req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        load_q  <= bus.req_load;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_bad;
        size_q  <= bus.req_size;
        off_q   <= bus.req_addr[1:0];
        idx_q   <= bus.req_addr[DEPTH_W+1:2];
        wdata_q <= bus.req_wdata;
      end
      if (state_q == RD) word_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad)                     state_d = RESP;
          else if (bus.req_load)           state_d = RD;
          else if (bus.req_size == SZ_WORD) state_d = WR;
          else                             state_d = RD;
        end
      end
      RD:      state_d = load_q ? RESP : WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In RESP word_q holds the loaded word; in WR it holds the old word for the merge.
  lsu_lane_align u_lane_align (
    .word_i     (word_q),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .off_i      (off_q),
    .unsigned_i (uns_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_comb begin
    mem_read  = (state_q == RD);
    mem_write = (state_q == WR);
    mem_addr  = (mem_read || mem_write) ? idx_q : '0;
    mem_wdata = mem_write ? merge_data : '0;
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign stall          = (state_q != IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && load_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops checked against
// an array-based memory model with arithmetic lane extraction.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_W(32)) bus ();

  logic        stall, mem_read, mem_write;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  load_store_unit #(.DEPTH_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic ld, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e_err, output logic [31:0] e_data,
                       output int e_lat, output int e_rd, output int e_wr);
    int idx, off, sh;
    logic [31:0] w, lane, mask;
    idx = int'(a[6:2]);
    off = int'(a[1:0]);
    e_err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && off != 0);
    e_data = 32'h0;
    e_rd   = 0;
    e_wr   = 0;
    e_lat  = 1;
    if (e_err) return;
    w = ref_mem[idx];
    if (sz == 2'b00)      begin sh = 8 * (3 - off);       mask = 32'h0000_00FF; end
    else if (sz == 2'b01) begin sh = 16 * (1 - off / 2);  mask = 32'h0000_FFFF; end
    else                  begin sh = 0;                   mask = 32'hFFFF_FFFF; end
    if (ld) begin
      lane = (w >> sh) & mask;
      if (!un && sz == 2'b00 && lane[7])  lane = lane | 32'hFFFF_FF00;
      if (!un && sz == 2'b01 && lane[15]) lane = lane | 32'hFFFF_0000;
      e_data = lane;
      e_lat  = 2;
      e_rd   = 1;
    end else begin
      ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      e_wr  = 1;
      e_rd  = (sz == 2'b10) ? 0 : 1;
      e_lat = (sz == 2'b10) ? 2 : 3;
    end
  endtask

  task automatic drive_req(input logic ld, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd);
    bus.req_load     = ld;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  task automatic do_op(input logic ld, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic        e_err, g_err, seen;
    logic [31:0] e_data;
    int e_lat, e_rd, e_wr, lat, rd_n, wr_n, guard, idx;
    idx = int'(a[6:2]);
    model(ld, sz, un, a, wd, e_err, e_data, e_lat, e_rd, e_wr);
    got   = 32'h0;
    g_err = 1'b0;
    @(negedge clk);
    drive_req(ld, sz, un, a, wd);
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drive_req($urandom % 2 == 1, 2'($urandom), $urandom % 2 == 1, $urandom, $urandom);
    lat = 0; rd_n = 0; wr_n = 0; seen = 1'b0;
    while (!seen && lat < 6) begin
      @(negedge clk);
      lat++;
      check_eq("busy_stall", stall, 1);
      check_eq("busy_ready", bus.req_ready, 0);
      check_eq("strobe_excl", mem_read & mem_write, 0);
      if (mem_read)  begin rd_n++; check_eq("rd_addr", mem_addr, idx); end
      if (mem_write) begin wr_n++; check_eq("wr_addr", mem_addr, idx); end
      if (bus.resp_valid) begin
        seen  = 1'b1;
        got   = bus.resp_rdata;
        g_err = bus.resp_err;
      end
    end
    check_eq("resp_seen", seen, 1);
    check_eq("latency", lat, e_lat);
    check_eq("resp_err", g_err, e_err);
    check_eq("resp_rdata", got, e_data);
    check_eq("rd_cycles", rd_n, e_rd);
    check_eq("wr_cycles", wr_n, e_wr);
    @(negedge clk);
    check_eq("post_idle_ready", bus.req_ready, 1);
    check_eq("post_idle_resp", bus.resp_valid, 0);
    check_eq("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, v, a;
    logic        b_err [3];
    logic [31:0] b_data [3];
    logic        b_ld [3];
    logic [1:0]  b_sz [3];
    logic [31:0] b_a [3], b_wd [3];
    int          e_lat, e_rd, e_wr, acc, resp_n, cyc;
    logic        ld, un;
    logic [1:0]  sz;

    bus.req_valid = 1'b0;
    drive_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      if (i == 2) v = 32'h8123_45F6;
      ref_mem[i] = v;
      mem[i] <= v;
    end

    #2;
    check_eq("rst_ready", bus.req_ready, 1);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_err", bus.resp_err, 0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 0);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 2'b00, 1'b0, 32'h08, 32'h0, got);  check_eq("lb_08", got, 32'hFFFF_FF81);
    do_op(1'b1, 2'b00, 1'b1, 32'h0B, 32'h0, got);  check_eq("lbu_0b", got, 32'h0000_00F6);
    do_op(1'b1, 2'b01, 1'b0, 32'h08, 32'h0, got);  check_eq("lh_08", got, 32'hFFFF_8123);
    do_op(1'b1, 2'b01, 1'b1, 32'h08, 32'h0, got);  check_eq("lhu_08", got, 32'h0000_8123);
    do_op(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0, got);  check_eq("lh_0a", got, 32'h0000_45F6);
    do_op(1'b0, 2'b00, 1'b0, 32'h09, 32'hAA, got);
    check_eq("sb_09_word", mem[2], 32'h81AA_45F6);
    do_op(1'b0, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF, got);
    check_eq("sw_0c_word", mem[3], 32'hDEAD_BEEF);
    do_op(1'b1, 2'b10, 1'b0, 32'h06, 32'h0, got);
    do_op(1'b0, 2'b11, 1'b0, 32'h04, 32'h1234_5678, got);

    // Reset during the read phase of a halfword store must leave memory untouched.
    @(negedge clk);
    drive_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h1234);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_in_rd", mem_read, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_read_drop", mem_read, 0);
    check_eq("abort_write_drop", mem_write, 0);
    check_eq("abort_ready", bus.req_ready, 1);
    check_eq("abort_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("abort_no_resp", bus.resp_valid, 0);
      check_eq("abort_no_write", mem_write, 0);
    end
    check_eq("abort_word2", mem[2], ref_mem[2]);

    // Back-to-back with req_valid held high.
    b_ld[0] = 1'b0; b_sz[0] = 2'b10; b_a[0] = 32'h10; b_wd[0] = 32'hCAFE_BABE;
    b_ld[1] = 1'b0; b_sz[1] = 2'b00; b_a[1] = 32'h13; b_wd[1] = 32'h0000_0055;
    b_ld[2] = 1'b1; b_sz[2] = 2'b01; b_a[2] = 32'h12; b_wd[2] = 32'h0;
    for (int i = 0; i < 3; i++)
      model(b_ld[i], b_sz[i], 1'b0, b_a[i], b_wd[i], b_err[i], b_data[i], e_lat, e_rd, e_wr);
    @(negedge clk);
    drive_req(b_ld[0], b_sz[0], 1'b0, b_a[0], b_wd[0]);
    bus.req_valid = 1'b1;
    acc = 0; resp_n = 0; cyc = 0;
    while (resp_n < 3 && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      check_eq("b2b_stall", stall, !bus.req_ready);
      if (bus.resp_valid) begin
        check_eq("b2b_err", bus.resp_err, b_err[resp_n]);
        check_eq("b2b_rdata", bus.resp_rdata, b_data[resp_n]);
        resp_n++;
      end
      if (bus.req_valid && bus.req_ready) begin
        @(posedge clk);
        #1;
        acc++;
        if (acc < 3) drive_req(b_ld[acc], b_sz[acc], 1'b0, b_a[acc], b_wd[acc]);
        else bus.req_valid = 1'b0;
      end
    end
    check_eq("b2b_accepts", acc, 3);
    check_eq("b2b_responses", resp_n, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b2b_no_extra", bus.resp_valid, 0);
    end
    check_eq("b2b_word4", mem[4], ref_mem[4]);

    for (int n = 0; n < 80; n++) begin
      ld = ($urandom % 2) == 1;
      un = ($urandom % 2) == 1;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom % 4 != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_op(ld, sz, un, a, $urandom, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator that sits between the pipeline's EX/MEM latch and the word-organised data memory. It owns the requester side of the memory port. It converts byte, halfword and word loads and stores into word-indexed memory reads and writes, using read-modify-write for sub-word stores. It extracts and sign- or zero-extends load results and stalls the pipeline while an access is in flight.

Parameters:
DEPTH_W, 5, word-index bits driven to memory (32 words)
DATA_W, 32, data and address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline presents a memory op
req_ready  out  1  high only in IDLE; request accepted on clk edge when req_valid & req_ready
req_load  in  1  1 = load, 0 = store
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  zero-extend loads (lbu/lhu)
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; misaligned or reserved size
resp_rdata  out  32  extended load data, valid with resp_valid
stall  out  1  = ~req_ready
mem_addr  out  DEPTH_W  word index = addr[DEPTH_W+1:2]
mem_wdata  out  32  word to write
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; latched request cleared.
- States: IDLE, RD, WR, RESP. All request fields are latched at acceptance. Later req_* changes are ignored until the next IDLE.
- Byte order is big-endian: byte offset 0 = bits [31:24]; half offset 0 = bits [31:16].
- Error check at accept: any of req_size=11, half with addr[0]=1, or word with addr[1:0]!=00 → IDLE→RESP, no memory strobes, resp_err=1, resp_rdata=0.
- Load: IDLE→RD→RESP.
  - In RD: mem_read=1. mem_rdata is registered at the end of RD.
  - In RESP: resp_rdata = the selected lane, sign-extended from bit 7/15 unless req_unsigned. Word loads pass through unchanged.
- Word store: IDLE→WR→RESP. In WR: mem_write=1, mem_wdata=req_wdata.
- Sub-word store: IDLE→RD→WR→RESP.
  - RD captures the old word.
  - WR writes the old word with only the addressed lane replaced by req_wdata[7:0] or [15:0].
  - resp_rdata=0 for stores.
- Latency counted from the accept edge at cycle N:
  - error: resp_valid in N+1
  - load or word store: resp_valid in N+2
  - sub-word store: resp_valid in N+3
- RESP→IDLE unconditionally. A new request can be accepted at the end of the IDLE cycle that follows RESP, so throughput is no better than one op per latency+1 cycles.
- Strobe rules:
  - mem_read and mem_write are decoded from state and are never high together.
  - Both strobes are 0 in IDLE and RESP.
  - mem_addr and mem_wdata are held stable for the full RD/WR cycle.
- Address bits above DEPTH_W+1 are ignored (wrap within memory). Width truncation is silent.
- Reset mid-operation: asynchronous return to IDLE. Strobes drop immediately, no partial write occurs, and no resp_valid is produced for the aborted op.
- req_valid while not ready: no effect. Requests are not queued.

Decomposition:
- Shared package `lsu_pkg`:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (IDLE, RD, WR, RESP)
  - function for misalignment check
- One natural sub-module: `lsu_lane_align`, purely combinational. It covers lane extraction with sign/zero extension and store-lane merge.
- The FSM and latches stay in the top module.

Test Plan:
- Preload word 2 = 0x812345F6:
  - lb 0x08 → 0xFFFFFF81
  - lbu 0x0B → 0x000000F6
  - lh 0x08 → 0xFFFF8123
  - lhu 0x08 → 0x00008123
  - lh 0x0A → 0x000045F6
  - each load: resp_valid at N+2, mem_read high exactly one cycle
- sb 0x09 with wdata 0x000000AA → word 2 = 0x81AA45F6. One RD cycle then one WR cycle; resp_valid at N+3.
- sw 0x0C with 0xDEADBEEF → word 3 = 0xDEADBEEF. mem_read never asserted; resp_valid at N+2.
- lw 0x06 and size=11 → resp_err=1 and resp_rdata=0 at N+1, no strobes; memory unchanged.
- Assert rst_n low during the RD cycle of sh 0x0A (wdata 0x1234) → word 2 unchanged, no resp_valid, req_ready=1 immediately.
- Hold req_valid high for 3 back-to-back ops → each accepted only when req_ready=1; stall matches ~req_ready; no op lost or duplicated.
